jump_trajectory: RTL

Flight-physics responder for the jump game. It is driven by the game state machine's jump request: it latches the launch speed and integrates a parabolic arc once per frame tick. It streams the man's jump height and horizontal distance back to the state machine, then signals landing with a held done level. It sits between the game state machine and the graphics path, clocked on the 25.175 MHz machine clock.

---
 rtl/jump_trajectory.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/jump_trajectory.sv
// jump_trajectory: flight physics for the jump game.
// Latches a launch speed on a jump request, integrates a unit-gravity
// parabola once per physics tick, streams height/distance and raises a
// held done level on landing.
// Optional build macro JUMP_TRAJ_TIMEOUT_EN: forces landing after
// MAX_TICKS flight ticks.
module jump_trajectory #(
  parameter int TICK_DIV  = 419583,
  parameter int H_SHIFT   = 5,
  parameter int D_SHIFT   = 7,
  parameter int MAX_TICKS = 300
) (
  input  logic        clk_jump,
  input  logic        rst_jump,
  input  logic        i_jump_en,
  input  logic [10:0] i_jump_v_init,
  output logic        o_jump_done,
  output logic [10:0] o_jump_dist,
  output logic [8:0]  o_jump_height,
  output logic        o_busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [6:0]          r_v, w_v_nxt;
  logic signed [8:0]   r_vy, w_vy_nxt;
  logic signed [14:0]  r_h_acc, w_h_acc_nxt;
  logic [15:0]         r_dist_acc, w_dist_acc_nxt;
  logic [CNT_W-1:0]    r_tick_cnt, w_tick_cnt_nxt;
  logic                w_done_nxt, w_busy_nxt;
  logic [10:0]         w_dist_nxt;
  logic [8:0]          w_height_nxt;

  logic [6:0]          w_v_sat;
  logic                w_tick;
  logic signed [14:0]  w_h_next;
  logic [14:0]         w_h_shift;
  logic [15:0]         w_dist_new;
  logic [15:0]         w_dist_shift;
  logic                w_land;
  logic                w_timeout;
  logic                w_unused;

  // Launch speed saturates at 127.
  assign w_v_sat      = (i_jump_v_init > 11'd127) ? 7'd127 : i_jump_v_init[6:0];
  assign w_tick       = (r_state == FLY) && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_h_next     = r_h_acc + {{6{r_vy[8]}}, r_vy};
  assign w_h_shift    = w_h_next >>> H_SHIFT;
  assign w_dist_new   = r_dist_acc + {9'd0, r_v};
  assign w_dist_shift = w_dist_new >> D_SHIFT;
  // Landing uses the pre-decrement vertical speed.
  assign w_land       = (r_vy <= 9'sd0) && (w_h_next <= 15'sd0);
  assign w_unused     = ^{w_h_shift[14:9], w_dist_shift[15:11]};

`ifdef JUMP_TRAJ_TIMEOUT_EN
  localparam int FC_W = $clog2(MAX_TICKS + 1);
  logic [FC_W-1:0] r_flight_cnt, w_flight_cnt_nxt;

  // This tick is the MAX_TICKS-th one of the flight.
  assign w_timeout = (r_flight_cnt == FC_W'(MAX_TICKS - 1));

  // Flight-tick counter: cleared on launch, advanced on each tick in FLY.
  always_comb begin
    w_flight_cnt_nxt = r_flight_cnt;
    if (r_state == IDLE && i_jump_en)
      w_flight_cnt_nxt = '0;
    else if (w_tick)
      w_flight_cnt_nxt = r_flight_cnt + 1'b1;
  end

  // Flight-tick counter register.
  always_ff @(posedge clk_jump or posedge rst_jump) begin
    if (rst_jump) r_flight_cnt <= '0;
    else          r_flight_cnt <= w_flight_cnt_nxt;
  end
`else
  localparam int MAX_TICKS_UNUSED = MAX_TICKS;
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_jump or posedge rst_jump) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_jump) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and next-datapath/output values.
  always_comb begin
    // NOTE: every target is given a hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_v_nxt        = r_v;
    w_vy_nxt       = r_vy;
    w_h_acc_nxt    = r_h_acc;
    w_dist_acc_nxt = r_dist_acc;
    w_tick_cnt_nxt = r_tick_cnt;
    w_done_nxt     = o_jump_done;
    w_dist_nxt     = o_jump_dist;
    w_height_nxt   = o_jump_height;
    w_busy_nxt     = o_busy;
    unique case (r_state)
      IDLE: begin
        if (i_jump_en) begin
          w_v_nxt        = w_v_sat;
          w_vy_nxt       = $signed({2'b00, w_v_sat});
          w_h_acc_nxt    = '0;
          w_dist_acc_nxt = '0;
          w_tick_cnt_nxt = '0;
          w_dist_nxt     = '0;
          w_height_nxt   = '0;
          w_done_nxt     = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = FLY;
        end
      end
      FLY: begin
        if (!i_jump_en) begin
          // Abort: distance is held, no landing indication.
          w_height_nxt = '0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
          if (w_tick) begin
            w_vy_nxt       = r_vy - 9'sd1;
            w_dist_acc_nxt = w_dist_new;
            w_dist_nxt     = w_dist_shift[10:0];
            if (w_land || w_timeout) begin
              w_h_acc_nxt  = '0;
              w_height_nxt = '0;
              w_done_nxt   = 1'b1;
              w_busy_nxt   = 1'b0;
              w_state_nxt  = DONE;
            end else begin
              w_h_acc_nxt  = w_h_next;
              w_height_nxt = w_h_shift[8:0];
            end
          end
        end
      end
      DONE: begin
        if (!i_jump_en) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_jump or posedge rst_jump) begin
    if (rst_jump) begin
      r_v           <= '0;
      r_vy          <= '0;
      r_h_acc       <= '0;
      r_dist_acc    <= '0;
      r_tick_cnt    <= '0;
      o_jump_done   <= 1'b0;
      o_jump_dist   <= '0;
      o_jump_height <= '0;
      o_busy        <= 1'b0;
    end else begin
      r_v           <= w_v_nxt;
      r_vy          <= w_vy_nxt;
      r_h_acc       <= w_h_acc_nxt;
      r_dist_acc    <= w_dist_acc_nxt;
      r_tick_cnt    <= w_tick_cnt_nxt;
      o_jump_done   <= w_done_nxt;
      o_jump_dist   <= w_dist_nxt;
      o_jump_height <= w_height_nxt;
      o_busy        <= w_busy_nxt;
    end
  end

endmodule
